// File: rtl/io_pkg.sv
// Shared definitions for the host IO dispatch block.
//   - IDLE/LOAD/CALC state codes and the state enum built from them
//   - obj_w():    width of the object counter for a given object budget
//   - lane_lsb(): bit offset of a lane inside the packed host word
package io_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CALC = 2'd2;

    // Code 3 is never entered on purpose; it exists so the decode can route it back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_LOAD    = LOAD,
        ST_CALC    = CALC,
        ST_ILLEGAL = 2'd3
    } state_t;

    // Counter width able to hold the values 0..n_obj inclusive.
    function automatic int obj_w(input int n_obj);
        return $clog2(n_obj + 1);
    endfunction

    // Lowest bit of lane 'lane' in a word made of lanes of 'lane_w' bits.
    function automatic int lane_lsb(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/io_obj_counter.sv
// Saturating object counter for the multi-object ("rest") lane.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   en          - one end-of-object event this cycle
//   clr         - clear count/done (start of a new load)
//   count       - objects completed so far, saturates at N_OBJ
//   done        - set on the edge where count reaches N_OBJ
//   next_pulse  - one-cycle pulse for every counted event
module io_obj_counter
    import io_pkg::*;
#(
    parameter int N_OBJ = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clr,
    output logic [obj_w(N_OBJ)-1:0]   count,
    output logic                      done,
    output logic                      next_pulse
);

    localparam int                 OBJ_W   = obj_w(N_OBJ);
    localparam logic [OBJ_W-1:0]   OBJ_MAX = OBJ_W'(N_OBJ);
    localparam logic [OBJ_W-1:0]   OBJ_ONE = OBJ_W'(1);

    logic [OBJ_W-1:0] count_r;
    logic             done_r;
    logic             next_r;

    // Count events until the budget is reached; events past saturation are dropped silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            done_r  <= 1'b0;
            next_r  <= 1'b0;
        end else if (clr) begin
            count_r <= '0;
            done_r  <= 1'b0;
            next_r  <= 1'b0;
        end else if (en && (count_r < OBJ_MAX)) begin
            count_r <= count_r + OBJ_ONE;
            done_r  <= ((count_r + OBJ_ONE) == OBJ_MAX);
            next_r  <= 1'b1;
        end else begin
            next_r  <= 1'b0;
        end
    end

    assign count      = count_r;
    assign done       = done_r;
    assign next_pulse = next_r;

endmodule

// File: rtl/io_dispatch_fsm.sv
// Host IO dispatch controller: IDLE -> LOAD -> CALC sequencer that splits
// host words into N_CH lanes and feeds the decompressors that are not done.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   irq, process            - host command (process=0 load, 1 calculate)
//   in_data/in_valid/in_ready - host beat handshake
//   lane_data, lane_start   - registered word and per-lane start strobes
//   lane_eob                - per-lane end-of-object from decompressors
//   lane_done               - sticky per-lane finish flags
//   obj_count, next         - rest-lane object count and next-object pulse
//   calc_start, coord_ready - coordinator hand-off and return
//   state                   - current state code for debug
module io_dispatch_fsm
    import io_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int LANE_W    = 8,
    parameter int N_OBJ     = 4,
    parameter bit AUTO_CALC = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      irq,
    input  logic                      process,
    input  logic [N_CH*LANE_W-1:0]    in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [N_CH*LANE_W-1:0]    lane_data,
    output logic [N_CH-1:0]           lane_start,
    input  logic [N_CH-1:0]           lane_eob,
    output logic [N_CH-1:0]           lane_done,
    output logic [obj_w(N_OBJ)-1:0]   obj_count,
    output logic                      next,
    output logic                      calc_start,
    input  logic                      coord_ready,
    output logic [1:0]                state
);

    localparam int OBJ_W = obj_w(N_OBJ);

    state_t                   state_r;
    logic                     calc_start_r;
    logic [N_CH*LANE_W-1:0]   lane_data_r;
    logic [N_CH-1:0]          lane_start_r;

    wire  [N_CH-2:0]          flag_s;
    logic [N_CH-1:0]          lane_done_s;
    logic                     all_done_s;
    logic                     in_ready_s;
    logic                     accept_s;
    logic                     load_entry_s;
    logic                     in_load_s;
    logic                     cnt_en_s;
    logic                     cnt_done_s;
    logic                     cnt_next_s;
    logic [OBJ_W-1:0]         cnt_s;

    assign in_load_s    = (state_r == ST_LOAD);
    assign load_entry_s = (state_r == ST_IDLE) && irq && !process;
    assign lane_done_s  = {cnt_done_s, flag_s};
    assign all_done_s   = &lane_done_s;
    // Ready is derived from registered flags only, so it never depends on same-cycle eob.
    assign in_ready_s   = in_load_s && !all_done_s;
    assign accept_s     = in_valid && in_ready_s;
    assign cnt_en_s     = in_load_s && lane_eob[N_CH-1];

    // Single-object lanes: sticky finish flag, cleared only when a new load starts.
    for (genvar i = 0; i < N_CH - 1; i++) begin : g_flag
        logic done_r;

        // Set on eob during LOAD, hold until the next IDLE->LOAD entry.
        always_ff @(posedge clk) begin
            if (reset) begin
                done_r <= 1'b0;
            end else if (load_entry_s) begin
                done_r <= 1'b0;
            end else if (in_load_s && lane_eob[i]) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end
        end

        assign flag_s[i] = done_r;
    end

    io_obj_counter #(
        .N_OBJ      (N_OBJ)
    ) u_obj_counter (
        .clk        (clk),
        .reset      (reset),
        .en         (cnt_en_s),
        .clr        (load_entry_s),
        .count      (cnt_s),
        .done       (cnt_done_s),
        .next_pulse (cnt_next_s)
    );

    // Capture accepted beats and strobe only the lanes that were still open before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_data_r  <= '0;
            lane_start_r <= '0;
        end else if (accept_s) begin
            for (int i = 0; i < N_CH; i++) begin
                lane_data_r[lane_lsb(i, LANE_W) +: LANE_W] <= in_data[lane_lsb(i, LANE_W) +: LANE_W];
            end
            lane_start_r <= ~lane_done_s;
        end else begin
            lane_start_r <= '0;
        end
    end

    // Control sequencer with registered calc_start pulse on CALC entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            calc_start_r <= 1'b0;
        end else begin
            calc_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (irq && !process) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // A load command while loading is ignored; only calculate or auto-complete leave LOAD.
                    if ((irq && process) || (AUTO_CALC && all_done_s)) begin
                        state_r      <= ST_CALC;
                        calc_start_r <= 1'b1;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_CALC: begin
                    if (coord_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign lane_data  = lane_data_r;
    assign lane_start = lane_start_r;
    assign lane_done  = lane_done_s;
    assign obj_count  = cnt_s;
    assign next       = cnt_next_s;
    assign calc_start = calc_start_r;
    assign state      = state_r;

endmodule

// File: tb/tb_io_dispatch_fsm.sv
// Bench for io_dispatch_fsm: two instances (AUTO_CALC=0 and 1) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_io_dispatch_fsm;

    localparam int N_CH   = 4;
    localparam int LANE_W = 8;
    localparam int N_OBJ  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq;
    logic        process;
    logic [31:0] in_data;
    logic        in_valid;
    logic [3:0]  lane_eob;
    logic        coord_ready;

    logic        rdy0, rdy1, next0, next1, calc0, calc1;
    logic [31:0] data0, data1;
    logic [3:0]  start0, start1, done0, done1;
    logic [2:0]  cnt0, cnt1;
    logic [1:0]  st0, st1;

    int checks   = 0;
    int failures = 0;

    // Behavioural model, one entry per instance (index = AUTO_CALC value).
    int          ms    [2];
    logic [3:0]  mdone [2];
    int          mcnt  [2];
    logic [31:0] mdata [2];
    logic [3:0]  mstart[2];
    logic        mnext [2];
    logic        mcalc [2];

    always #5 clk = ~clk;

    io_dispatch_fsm #(.N_CH(N_CH), .LANE_W(LANE_W), .N_OBJ(N_OBJ), .AUTO_CALC(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .irq(irq), .process(process),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
        .lane_data(data0), .lane_start(start0), .lane_eob(lane_eob),
        .lane_done(done0), .obj_count(cnt0), .next(next0),
        .calc_start(calc0), .coord_ready(coord_ready), .state(st0)
    );

    io_dispatch_fsm #(.N_CH(N_CH), .LANE_W(LANE_W), .N_OBJ(N_OBJ), .AUTO_CALC(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .irq(irq), .process(process),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
        .lane_data(data1), .lane_start(start1), .lane_eob(lane_eob),
        .lane_done(done1), .obj_count(cnt1), .next(next1),
        .calc_start(calc1), .coord_ready(coord_ready), .state(st1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            logic all_done;
            logic accept;
            all_done = (mdone[m] == 4'hF);
            accept   = in_valid && (ms[m] == 1) && !all_done;
            if (reset) begin
                ms[m] = 0; mdone[m] = 4'h0; mcnt[m] = 0; mdata[m] = 32'h0;
                mstart[m] = 4'h0; mnext[m] = 1'b0; mcalc[m] = 1'b0;
            end else begin
                mstart[m] = accept ? ~mdone[m] : 4'h0;
                if (accept) mdata[m] = in_data;
                mnext[m] = 1'b0;
                mcalc[m] = 1'b0;
                if (ms[m] == 0) begin
                    if (irq && !process) begin
                        ms[m] = 1; mdone[m] = 4'h0; mcnt[m] = 0;
                    end
                end else if (ms[m] == 1) begin
                    for (int i = 0; i < N_CH - 1; i++) if (lane_eob[i]) mdone[m][i] = 1'b1;
                    if (lane_eob[N_CH-1] && mcnt[m] < N_OBJ) begin
                        mcnt[m]++;
                        mnext[m] = 1'b1;
                        if (mcnt[m] == N_OBJ) mdone[m][N_CH-1] = 1'b1;
                    end
                    if ((irq && process) || (m == 1 && all_done)) begin
                        ms[m] = 2; mcalc[m] = 1'b1;
                    end
                end else begin
                    if (coord_ready) ms[m] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic exp_rdy;
            exp_rdy = (ms[m] == 1) && (mdone[m] != 4'hF);
            chk($sformatf("a%0d_state", m), (m == 0) ? 32'(st0)    : 32'(st1),    32'(ms[m]));
            chk($sformatf("a%0d_ready", m), (m == 0) ? 32'(rdy0)   : 32'(rdy1),   32'(exp_rdy));
            chk($sformatf("a%0d_data",  m), (m == 0) ? data0       : data1,       mdata[m]);
            chk($sformatf("a%0d_start", m), (m == 0) ? 32'(start0) : 32'(start1), 32'(mstart[m]));
            chk($sformatf("a%0d_done",  m), (m == 0) ? 32'(done0)  : 32'(done1),  32'(mdone[m]));
            chk($sformatf("a%0d_count", m), (m == 0) ? 32'(cnt0)   : 32'(cnt1),   32'(mcnt[m]));
            chk($sformatf("a%0d_next",  m), (m == 0) ? 32'(next0)  : 32'(next1),  32'(mnext[m]));
            chk($sformatf("a%0d_calc",  m), (m == 0) ? 32'(calc0)  : 32'(calc1),  32'(mcalc[m]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        irq = 1'b0; process = 1'b0; in_valid = 1'b0; lane_eob = 4'h0; coord_ready = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            ms[m] = 0; mdone[m] = 4'h0; mcnt[m] = 0; mdata[m] = 32'h0;
            mstart[m] = 4'h0; mnext[m] = 1'b0; mcalc[m] = 1'b0;
        end
        reset = 1'b1; in_data = 32'h0; idle_inputs();
        @(negedge clk);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Start a load.
        irq = 1'b1; process = 1'b0; tick();
        idle_inputs();

        // Two beats, with lane 0 finishing in between.
        in_valid = 1'b1; in_data = 32'h44332211; tick();
        in_valid = 1'b0; lane_eob = 4'b0001; tick();
        lane_eob = 4'h0; in_valid = 1'b1; in_data = 32'hAABBCCDD; tick();
        in_valid = 1'b0; tick();

        // Five eob events on the rest lane; the fifth must saturate.
        for (int k = 0; k < 5; k++) begin
            lane_eob = 4'b1000; tick();
            lane_eob = 4'b0000; tick();
        end

        // Finish remaining lanes; a beat offered now must be refused.
        lane_eob = 4'b0110; tick();
        lane_eob = 4'h0; in_valid = 1'b1; in_data = 32'h12345678; tick();
        in_valid = 1'b0; tick(); tick();

        // Calculate command, then coordinator return.
        irq = 1'b1; process = 1'b1; tick();
        idle_inputs(); tick();
        coord_ready = 1'b1; tick(); tick();
        coord_ready = 1'b0;

        // New load clears everything; then reset lands on a pending beat.
        irq = 1'b1; process = 1'b0; tick();
        idle_inputs();
        lane_eob = 4'b0101; tick();
        lane_eob = 4'h0; in_valid = 1'b1; in_data = 32'hCAFEF00D; reset = 1'b1; tick();
        reset = 1'b0; idle_inputs(); tick();

        // Randomised traffic.
        for (int c = 0; c < 2000; c++) begin
            logic [3:0] eob;
            for (int i = 0; i < N_CH; i++) eob[i] = ($urandom_range(0, 7) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            irq         = ($urandom_range(0, 15) == 0);
            process     = 1'($urandom_range(0, 1));
            in_valid    = 1'($urandom_range(0, 1));
            in_data     = $urandom;
            lane_eob    = eob;
            coord_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_dispatch_fsm.md
Name: io_dispatch_fsm

Overview:
- Parametrised successor of the accelerator's host IO controller.
- Accepts packed words from the host bus and splits them into N_CH lanes of LANE_W bits. Dispatches each word to the per-lane decompressors that have not yet finished, tracks sticky per-lane end-of-object flags and counts objects on the last ("rest") lane.
- Sequences IDLE -> LOAD -> CALC and hands off to the coordinator.
- Adds a valid/ready input handshake, optional auto-transition to CALC, and a coordinator-ready return path.

Parameters:
- N_CH, 4, number of lanes/decompressors; lane N_CH-1 is the multi-object "rest" lane.
- LANE_W, 8, bits per lane; bus width is N_CH*LANE_W.
- N_OBJ, 4, objects expected on lane N_CH-1 before it is done (>=1).
- AUTO_CALC, 0, 1 = enter CALC automatically when all lanes are done.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- irq  in  1  host interrupt; qualified by process.
- process  in  1  mode with irq: 0 = start load, 1 = start calculate.
- in_data  in  N_CH*LANE_W  packed host word; lane i = bits [i*LANE_W +: LANE_W].
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a beat this cycle.
- lane_data  out  N_CH*LANE_W  registered copy of the last accepted word.
- lane_start  out  N_CH  one-cycle strobe per lane, aligned with lane_data.
- lane_eob  in  N_CH  per-lane end-of-object from the decompressors.
- lane_done  out  N_CH  sticky finish flags.
- obj_count  out  $clog2(N_OBJ+1)  objects completed on lane N_CH-1.
- next  out  1  one-cycle pulse requesting the next object.
- calc_start  out  1  one-cycle pulse on entry to CALC.
- coord_ready  in  1  coordinator has finished calculation.
- state  out  2  current state, for debug.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE(2'd0); in_ready, lane_start, lane_done, obj_count, next and calc_start all 0; lane_data 0.
- State encoding: IDLE=0, LOAD=1, CALC=2. Code 3 is unreachable and decodes to IDLE on the next edge.
- IDLE:
  - in_ready=0.
  - irq & !process -> LOAD. The same edge clears lane_done and obj_count.
  - All other inputs are ignored.
- LOAD:
  - in_ready = ~&lane_done (combinational from registered flags).
  - Beat accepted when in_valid & in_ready. At that edge, lane_data <= in_data and lane_start[i] <= ~lane_done[i], using the flags before any same-cycle update.
  - lane_start is 0 in every cycle without an accepted beat.
- End-of-object, lanes i < N_CH-1: lane_eob[i] in LOAD sets lane_done[i]. The flag stays set until the next IDLE->LOAD transition.
- End-of-object, lane N_CH-1: lane_eob[N_CH-1] while obj_count < N_OBJ increments obj_count and pulses next for one cycle, registered.
  - lane_done[N_CH-1] sets on the edge where obj_count becomes N_OBJ; next still pulses on that edge.
  - obj_count saturates at N_OBJ; further eob on that lane is ignored and gives no next pulse.
- lane_eob is ignored outside LOAD.
- Leaving LOAD:
  - irq & process -> CALC.
  - If AUTO_CALC=1, also -> CALC on the cycle after all lane_done bits are 1.
  - A beat accepted on the transition edge is still dispatched.
  - irq & !process while in LOAD is ignored; it does not restart.
- CALC:
  - in_ready=0.
  - calc_start=1 in the first cycle in CALC only.
  - coord_ready -> IDLE. coord_ready in the first CALC cycle is honoured, giving a 1-cycle CALC.
  - irq is ignored.
- Latency: accepted beat -> lane_data/lane_start valid the next cycle. eob -> lane_done/next update the next cycle.
- Reset mid-operation: any state returns to IDLE next edge; all flags and counters are cleared, and in-flight strobes are dropped.

Decomposition:
- Shared package io_pkg:
  - state localparams IDLE/LOAD/CALC;
  - OBJ_W function ($clog2(N_OBJ+1));
  - lane slice helper.
- One natural sub-module: io_obj_counter. It is the saturating counter for lane N_CH-1, with inputs en/clr and outputs count/done/next_pulse, parametrised by N_OBJ.
- Lane flag logic stays inline as a generate loop.

Test Plan:
- Reset, then irq=1 & process=0 -> state=1 next cycle; in_ready=1; lane_done=0; obj_count=0.
- In LOAD with in_data=0x44332211 and in_valid=1 -> next cycle lane_data=0x44332211, lane_start=4'b1111. Set lane_eob=4'b0001, then send 0xAABBCCDD -> lane_start=4'b1110.
- Pulse lane_eob[3] four times (N_OBJ=4) -> obj_count counts 1..4 and next pulses 4 times. lane_done[3] is set after the 4th. A 5th eob gives no next and obj_count stays 4.
- With lane_done=4'b1111 -> in_ready=0. AUTO_CALC=1 -> state=2 with calc_start pulse. AUTO_CALC=0 -> stays in LOAD until irq & process.
- In CALC assert coord_ready -> state=0 next cycle. A following irq & !process clears lane_done/obj_count on entry to LOAD.
- Assert reset in LOAD mid-beat with lane_done=4'b0101 -> next cycle state=0, all outputs 0, and the pending lane_start is suppressed.
